// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: shared funct3 size codes, FSM states and byte-mask helpers for the LSU memory stage.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // funct3[1:0] encodes the access size for both signed and unsigned variants
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return (sz == 2'b00) ? MASK_B : (sz == 2'b01) ? MASK_H : (sz == 2'b10) ? MASK_W : MASK_D;
    endfunction

    // alignment bits that must be zero: H -> [0], W -> [1:0], D -> [2:0]
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        return |(off & {&sz, sz[1], |sz});
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the aligned 64-bit read word down to the accessed lane, truncates to size
// and sign/zero-extends.
//   i_rdata  : aligned read data from the bus
//   i_off    : byte offset within the word (addr[2:0])
//   i_funct3 : size/sign code (111 treated as D)
//   o_data   : extended load result
module lsu_load_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] sh;

    assign sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_H:    o_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_W:    o_data = {{(XLEN-32){sh[31]}}, sh[31:0]};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, sh[15:0]};
            F3_WU:   o_data = {{(XLEN-32){1'b0}}, sh[31:0]};
            F3_D:    o_data = sh;
            default: o_data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: EX->WB memory stage; passes non-memory ops in one cycle and runs loads/stores over a
// single-outstanding req/ack bus, registering the WB bundle.
//   i_clk/i_rst_n              : clock, asynchronous active-low reset
//   i_EX_* / o_EX_ready        : EX bundle handshake (ready only while IDLE)
//   o_mem_* / i_mem_*          : data bus; request held until the 1-cycle ack
//   o_WB_*                     : WB bundle, valid is a 1-cycle pulse, enables gated by valid and rd!=0
//   o_misalign/o_misalign_addr : present only when LSU_MISALIGN_TRAP_EN is defined
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses skip the bus and flag a trap).
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_EX_valid,
    output logic               o_EX_ready,
    input  logic [XLEN-1:0]    i_EX_alu_res,
    input  logic [XLEN-1:0]    i_EX_store_data,
    input  logic               i_EX_mem_read,
    input  logic               i_EX_mem_write,
    input  logic [2:0]         i_EX_funct3,
    input  logic               i_EX_RegWrite,
    input  logic [RADDR_W-1:0] i_EX_reg_wr_addr,
    input  logic               i_EX_csr_reg_write,
    input  logic [XLEN-1:0]    i_EX_csr_r_data,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [XLEN-1:0]    o_mem_addr,
    output logic [XLEN-1:0]    o_mem_wdata,
    output logic [7:0]         o_mem_wmask,
    input  logic               i_mem_ack,
    input  logic [XLEN-1:0]    i_mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic               o_misalign,
    output logic [XLEN-1:0]    o_misalign_addr,
`endif
    output logic               o_WB_valid,
    output logic [XLEN-1:0]    o_WB_reg_wr_data,
    output logic               o_WB_RegWrite,
    output logic [RADDR_W-1:0] o_WB_reg_wr_addr,
    output logic               o_WB_csr_reg_write,
    output logic [XLEN-1:0]    o_WB_csr_r_data
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    addr_q, wdata_q, csr_data_q;
    logic [7:0]         wmask_q;
    logic [2:0]         f3_q;
    logic [RADDR_W-1:0] rd_q;
    logic               we_q, rw_q, csr_q;
    logic               wb_valid_q, wb_rw_q, wb_csr_q;
    logic [XLEN-1:0]    wb_data_q, wb_csr_data_q;
    logic [RADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]    wb_data_d, wb_csr_data_d, wdata_d, load_data;
    logic [RADDR_W-1:0] wb_rd_d;
    logic               wb_rw_d, wb_csr_d;
    logic [7:0]         wmask_d;
    logic               accept, is_mem, misal, start, pass, done, wb_load;

    assign accept  = i_EX_valid & (state_q == S_IDLE);
    assign is_mem  = i_EX_mem_read | i_EX_mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misal   = is_mem & misaligned(i_EX_funct3[1:0], i_EX_alu_res[2:0]);
`else
    assign misal   = 1'b0;
`endif
    assign start   = accept & is_mem & ~misal;
    // non-memory ops and trapped accesses complete straight from IDLE
    assign pass    = accept & ~start;
    assign done    = (state_q == S_WAIT) & i_mem_ack;
    assign wb_load = pass | done;

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_rdata  (i_mem_rdata),
        .i_off    (addr_q[2:0]),
        .i_funct3 (f3_q),
        .o_data   (load_data)
    );

    always_comb begin
        state_d       = start ? S_WAIT : (done ? S_IDLE : state_q);
        wmask_d       = i_EX_mem_write ? size_mask(i_EX_funct3[1:0]) << i_EX_alu_res[2:0] : 8'h00;
        wdata_d       = i_EX_store_data << {i_EX_alu_res[2:0], 3'b000};
        wb_data_d     = done ? (we_q ? addr_q : load_data) : i_EX_alu_res;
        wb_rd_d       = done ? rd_q : i_EX_reg_wr_addr;
        wb_csr_data_d = done ? csr_data_q : i_EX_csr_r_data;
        // stores never write a GPR; a trapped access never writes either
        wb_rw_d       = wb_load & (done ? rw_q & ~we_q & (rd_q != '0)
                                        : i_EX_RegWrite & ~misal & (i_EX_reg_wr_addr != '0));
        wb_csr_d      = wb_load & (done ? csr_q & (rd_q != '0)
                                        : i_EX_csr_reg_write & (i_EX_reg_wr_addr != '0));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            we_q          <= 1'b0;
            f3_q          <= '0;
            rd_q          <= '0;
            rw_q          <= 1'b0;
            csr_q         <= 1'b0;
            csr_data_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_rw_q       <= 1'b0;
            wb_csr_q      <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_csr_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_load;
            wb_rw_q    <= wb_rw_d;
            wb_csr_q   <= wb_csr_d;
            if (start) begin
                addr_q     <= i_EX_alu_res;
                wdata_q    <= wdata_d;
                wmask_q    <= wmask_d;
                we_q       <= i_EX_mem_write;
                f3_q       <= i_EX_funct3;
                rd_q       <= i_EX_reg_wr_addr;
                rw_q       <= i_EX_RegWrite;
                csr_q      <= i_EX_csr_reg_write;
                csr_data_q <= i_EX_csr_r_data;
            end
            if (wb_load) begin
                wb_data_q     <= wb_data_d;
                wb_rd_q       <= wb_rd_d;
                wb_csr_data_q <= wb_csr_data_d;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q <= pass & misal;
            if (pass & misal)
                misalign_addr_q <= i_EX_alu_res;
        end
    end

    assign o_misalign      = misalign_q;
    assign o_misalign_addr = misalign_addr_q;
`endif

    assign o_EX_ready         = (state_q == S_IDLE);
    assign o_mem_req          = (state_q == S_WAIT);
    assign o_mem_we           = we_q;
    assign o_mem_addr         = {addr_q[XLEN-1:3], 3'b000};
    assign o_mem_wdata        = wdata_q;
    assign o_mem_wmask        = wmask_q;
    assign o_WB_valid         = wb_valid_q;
    assign o_WB_reg_wr_data   = wb_data_q;
    assign o_WB_RegWrite      = wb_rw_q;
    assign o_WB_reg_wr_addr   = wb_rd_q;
    assign o_WB_csr_reg_write = wb_csr_q;
    assign o_WB_csr_r_data    = wb_csr_data_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage (passthrough, loads, stores, reset, trap).
module tb_lsu_mem_stage;

    logic        i_clk, i_rst_n;
    logic        i_EX_valid, o_EX_ready;
    logic [63:0] i_EX_alu_res, i_EX_store_data, i_EX_csr_r_data;
    logic        i_EX_mem_read, i_EX_mem_write, i_EX_RegWrite, i_EX_csr_reg_write;
    logic [2:0]  i_EX_funct3;
    logic [4:0]  i_EX_reg_wr_addr;
    logic        o_mem_req, o_mem_we, i_mem_ack;
    logic [63:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [7:0]  o_mem_wmask;
    logic        o_WB_valid, o_WB_RegWrite, o_WB_csr_reg_write;
    logic [63:0] o_WB_reg_wr_data, o_WB_csr_r_data;
    logic [4:0]  o_WB_reg_wr_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        o_misalign;
    logic [63:0] o_misalign_addr;
`endif

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.XLEN(64), .RADDR_W(5)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_EX_valid         (i_EX_valid),
        .o_EX_ready         (o_EX_ready),
        .i_EX_alu_res       (i_EX_alu_res),
        .i_EX_store_data    (i_EX_store_data),
        .i_EX_mem_read      (i_EX_mem_read),
        .i_EX_mem_write     (i_EX_mem_write),
        .i_EX_funct3        (i_EX_funct3),
        .i_EX_RegWrite      (i_EX_RegWrite),
        .i_EX_reg_wr_addr   (i_EX_reg_wr_addr),
        .i_EX_csr_reg_write (i_EX_csr_reg_write),
        .i_EX_csr_r_data    (i_EX_csr_r_data),
        .o_mem_req          (o_mem_req),
        .o_mem_we           (o_mem_we),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wdata        (o_mem_wdata),
        .o_mem_wmask        (o_mem_wmask),
        .i_mem_ack          (i_mem_ack),
        .i_mem_rdata        (i_mem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .o_misalign         (o_misalign),
        .o_misalign_addr    (o_misalign_addr),
`endif
        .o_WB_valid         (o_WB_valid),
        .o_WB_reg_wr_data   (o_WB_reg_wr_data),
        .o_WB_RegWrite      (o_WB_RegWrite),
        .o_WB_reg_wr_addr   (o_WB_reg_wr_addr),
        .o_WB_csr_reg_write (o_WB_csr_reg_write),
        .o_WB_csr_r_data    (o_WB_csr_r_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic mem_op(input string tag, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int dly, input logic [7:0] emask,
                          input logic [63:0] ewdata, input logic [63:0] eres, input logic erw);
        i_EX_valid       = 1'b1;
        i_EX_mem_read    = rd_en;
        i_EX_mem_write   = wr_en;
        i_EX_funct3      = f3;
        i_EX_reg_wr_addr = rd;
        i_EX_alu_res     = addr;
        i_EX_store_data  = sdata;
        i_EX_RegWrite    = 1'b1;
        chk({tag, ".ready_idle"}, 64'(o_EX_ready), 64'd1);
        step;
        i_EX_valid     = 1'b0;
        i_EX_mem_read  = 1'b0;
        i_EX_mem_write = 1'b0;
        for (int k = 0; k <= dly; k++) begin
            chk({tag, ".req"}, 64'(o_mem_req), 64'd1);
            chk({tag, ".ready_wait"}, 64'(o_EX_ready), 64'd0);
            chk({tag, ".addr"}, o_mem_addr, addr & ~64'h7);
            chk({tag, ".we"}, 64'(o_mem_we), 64'(wr_en));
            chk({tag, ".wb_idle"}, 64'(o_WB_valid), 64'd0);
            if (wr_en) begin
                chk({tag, ".wmask"}, 64'(o_mem_wmask), 64'(emask));
                chk({tag, ".wdata"}, o_mem_wdata, ewdata);
            end
            if (k == dly) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = rdata;
            end
            step;
        end
        i_mem_ack = 1'b0;
        chk({tag, ".wb_valid"}, 64'(o_WB_valid), 64'd1);
        chk({tag, ".req_drop"}, 64'(o_mem_req), 64'd0);
        chk({tag, ".ready_back"}, 64'(o_EX_ready), 64'd1);
        chk({tag, ".regwrite"}, 64'(o_WB_RegWrite), 64'(erw));
        chk({tag, ".rd"}, 64'(o_WB_reg_wr_addr), 64'(rd));
        if (!wr_en)
            chk({tag, ".data"}, o_WB_reg_wr_data, eres);
        step;
        chk({tag, ".wb_pulse"}, 64'(o_WB_valid), 64'd0);
    endtask

    localparam logic [63:0] R = 64'h8011_2233_4455_6677;

    initial begin
        i_rst_n = 1'b0;
        i_EX_valid = 1'b0;
        i_EX_alu_res = '0;
        i_EX_store_data = '0;
        i_EX_csr_r_data = '0;
        i_EX_mem_read = 1'b0;
        i_EX_mem_write = 1'b0;
        i_EX_RegWrite = 1'b0;
        i_EX_csr_reg_write = 1'b0;
        i_EX_funct3 = '0;
        i_EX_reg_wr_addr = '0;
        i_mem_ack = 1'b0;
        i_mem_rdata = '0;
        #2;
        chk("rst.wb_valid", 64'(o_WB_valid), 64'd0);
        chk("rst.req", 64'(o_mem_req), 64'd0);
        chk("rst.we", 64'(o_mem_we), 64'd0);
        chk("rst.addr", o_mem_addr, 64'd0);
        chk("rst.wmask", 64'(o_mem_wmask), 64'd0);
        chk("rst.data", o_WB_reg_wr_data, 64'd0);
        chk("rst.regwrite", 64'(o_WB_RegWrite), 64'd0);
        chk("rst.ready", 64'(o_EX_ready), 64'd1);
        step;
        step;
        i_rst_n = 1'b1;

        // three back-to-back ALU ops
        i_EX_valid = 1'b1;
        i_EX_RegWrite = 1'b1;
        i_EX_reg_wr_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            i_EX_alu_res = 64'h1234 + 64'(i);
            chk("add.ready", 64'(o_EX_ready), 64'd1);
            step;
            chk("add.valid", 64'(o_WB_valid), 64'd1);
            chk("add.data", o_WB_reg_wr_data, 64'h1234 + 64'(i));
            chk("add.regwrite", 64'(o_WB_RegWrite), 64'd1);
            chk("add.rd", 64'(o_WB_reg_wr_addr), 64'd5);
        end
        i_EX_valid = 1'b0;
        step;
        chk("add.idle_valid", 64'(o_WB_valid), 64'd0);
        chk("add.idle_regwrite", 64'(o_WB_RegWrite), 64'd0);
        chk("add.hold_data", o_WB_reg_wr_data, 64'h1236);

        // rd = 0 gates both enables
        i_EX_valid = 1'b1;
        i_EX_reg_wr_addr = 5'd0;
        i_EX_csr_reg_write = 1'b1;
        i_EX_csr_r_data = 64'hC5;
        step;
        chk("rd0.valid", 64'(o_WB_valid), 64'd1);
        chk("rd0.regwrite", 64'(o_WB_RegWrite), 64'd0);
        chk("rd0.csr_we", 64'(o_WB_csr_reg_write), 64'd0);
        chk("rd0.csr_data", o_WB_csr_r_data, 64'hC5);

        // CSR read passes through
        i_EX_reg_wr_addr = 5'd7;
        i_EX_RegWrite = 1'b0;
        i_EX_csr_r_data = 64'hDEAD;
        step;
        chk("csr.we", 64'(o_WB_csr_reg_write), 64'd1);
        chk("csr.data", o_WB_csr_r_data, 64'hDEAD);
        chk("csr.regwrite", 64'(o_WB_RegWrite), 64'd0);
        i_EX_valid = 1'b0;
        i_EX_csr_reg_write = 1'b0;
        step;
        chk("csr.idle_we", 64'(o_WB_csr_reg_write), 64'd0);

        // stray ack in IDLE
        i_mem_ack = 1'b1;
        i_mem_rdata = '1;
        step;
        i_mem_ack = 1'b0;
        chk("stray.valid", 64'(o_WB_valid), 64'd0);
        chk("stray.req", 64'(o_mem_req), 64'd0);
        chk("stray.ready", 64'(o_EX_ready), 64'd1);

        // loads
        mem_op("LB",    1, 0, 3'b000, 5'd10, 64'h1007, 0, R, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 1);
        mem_op("LBU",   1, 0, 3'b100, 5'd10, 64'h1007, 0, R, 0, 0, 0, 64'h80, 1);
        mem_op("LB1",   1, 0, 3'b000, 5'd11, 64'h1001, 0, R, 0, 0, 0, 64'h66, 1);
        mem_op("LH",    1, 0, 3'b001, 5'd12, 64'h1006, 0, R, 1, 0, 0, 64'hFFFF_FFFF_FFFF_8011, 1);
        mem_op("LHU",   1, 0, 3'b101, 5'd13, 64'h1002, 0, R, 0, 0, 0, 64'h4455, 1);
        mem_op("LW",    1, 0, 3'b010, 5'd14, 64'h1004, 0, R, 2, 0, 0, 64'hFFFF_FFFF_8011_2233, 1);
        mem_op("LWU",   1, 0, 3'b110, 5'd15, 64'h1000, 0, R, 0, 0, 0, 64'h4455_6677, 1);
        mem_op("LD",    1, 0, 3'b011, 5'd3,  64'h1008, 0, 64'h0123_4567_89AB_CDEF, 4, 0, 0,
               64'h0123_4567_89AB_CDEF, 1);
        mem_op("LD111", 1, 0, 3'b111, 5'd16, 64'h1000, 0, R, 0, 0, 0, R, 1);
        mem_op("LBrd0", 1, 0, 3'b000, 5'd0,  64'h1007, 0, R, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0);

        // stores
        mem_op("SH", 0, 1, 3'b001, 5'd9, 64'h2006, 64'h1234, 0, 1, 8'hC0, 64'h1234_0000_0000_0000, 0, 0);
        mem_op("SB", 0, 1, 3'b000, 5'd9, 64'h2003, 64'h1122_3344_5566_77AB, 0, 0, 8'h08,
               64'h4455_6677_AB00_0000, 0, 0);
        mem_op("SW", 0, 1, 3'b010, 5'd9, 64'h2004, 64'h1122_3344_5566_7788, 0, 0, 8'hF0,
               64'h5566_7788_0000_0000, 0, 0);
        mem_op("SDrw", 1, 1, 3'b011, 5'd9, 64'h2000, 64'h1122_3344_5566_7788, R, 2, 8'hFF,
               64'h1122_3344_5566_7788, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
        mem_op("SWmis", 0, 1, 3'b010, 5'd9, 64'h2006, 64'h1122_3344_5566_7788, 0, 0, 8'hC0,
               64'h7788_0000_0000_0000, 0, 0);
`endif

        // reset while waiting for ack
        i_EX_valid = 1'b1;
        i_EX_mem_read = 1'b1;
        i_EX_alu_res = 64'h4000;
        i_EX_funct3 = 3'b011;
        i_EX_reg_wr_addr = 5'd8;
        step;
        i_EX_valid = 1'b0;
        i_EX_mem_read = 1'b0;
        chk("rstw.req_before", 64'(o_mem_req), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rstw.req_async", 64'(o_mem_req), 64'd0);
        chk("rstw.ready", 64'(o_EX_ready), 64'd1);
        #2 i_rst_n = 1'b1;
        step;
        i_mem_ack = 1'b1;
        i_mem_rdata = R;
        step;
        i_mem_ack = 1'b0;
        chk("rstw.late_ack_valid", 64'(o_WB_valid), 64'd0);
        chk("rstw.late_ack_req", 64'(o_mem_req), 64'd0);

        // stage still works afterwards
        i_EX_valid = 1'b1;
        i_EX_RegWrite = 1'b1;
        i_EX_reg_wr_addr = 5'd6;
        i_EX_alu_res = 64'h55;
        step;
        i_EX_valid = 1'b0;
        chk("post.valid", 64'(o_WB_valid), 64'd1);
        chk("post.data", o_WB_reg_wr_data, 64'h55);

`ifdef LSU_MISALIGN_TRAP_EN
        i_EX_valid = 1'b1;
        i_EX_mem_read = 1'b1;
        i_EX_funct3 = 3'b010;
        i_EX_alu_res = 64'h3002;
        i_EX_reg_wr_addr = 5'd4;
        i_EX_RegWrite = 1'b1;
        step;
        i_EX_valid = 1'b0;
        i_EX_mem_read = 1'b0;
        chk("mis.req", 64'(o_mem_req), 64'd0);
        chk("mis.valid", 64'(o_WB_valid), 64'd1);
        chk("mis.flag", 64'(o_misalign), 64'd1);
        chk("mis.addr", o_misalign_addr, 64'h3002);
        chk("mis.regwrite", 64'(o_WB_RegWrite), 64'd0);
        chk("mis.ready", 64'(o_EX_ready), 64'd1);
        step;
        chk("mis.flag_pulse", 64'(o_misalign), 64'd0);
        chk("mis.req_after", 64'(o_mem_req), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
